// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD constants and helpers for the counter family
package bcd_pkg;
  localparam int BCD_DIGIT_W = 4;
  function automatic logic bcd_digit_valid(input logic [BCD_DIGIT_W-1:0] nibble);
    return nibble <= 4'd9;
  endfunction
  // 99..9 with the given number of digits, zero-extended to 16 digits
  function automatic logic [63:0] bcd_all_ones(input int digits);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 16; i++)
      if (i < digits) r[i*BCD_DIGIT_W +: BCD_DIGIT_W] = 4'd9;
    return r;
  endfunction
endpackage

// File: rtl/bcd_digit_step.sv
// bcd_digit_step: single BCD digit +/-1 gated by a carry/borrow in
module bcd_digit_step
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] d_i,
  input  logic                   dn_i,
  input  logic                   ci_i,
  output logic [BCD_DIGIT_W-1:0] q_o,
  output logic                   co_o
);
  // up: 9 -> 0 with carry; down: 0 -> 9 with borrow; no ci means pass-through
  always_comb begin
    co_o = ci_i && (dn_i ? d_i == 4'd0 : d_i == 4'd9);
    q_o  = !ci_i ? d_i :
           dn_i  ? (d_i == 4'd0 ? 4'd9 : d_i - 4'd1) :
                   (d_i == 4'd9 ? 4'd0 : d_i + 4'd1);
  end
endmodule

// File: rtl/bcd_counter_nd.sv
// bcd_counter_nd: N-digit BCD counter with live modulus, up/down, checked load, wrap pulse
module bcd_counter_nd
  import bcd_pkg::*;
#(
  parameter int               DIGITS    = 4,
  parameter logic [4*DIGITS-1:0] RESET_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  dir,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic [4*DIGITS-1:0]   bcd_max,
  output logic [4*DIGITS-1:0]   count,
  output logic                  wrap,
  output logic                  load_err,
  output logic                  at_zero
);
  localparam int W = BCD_DIGIT_W * DIGITS;
  localparam logic [63:0] ALL_NINES = bcd_all_ones(DIGITS);
  logic [W-1:0] count_q, count_d, inc, dec, max_dec, m_minus1;
  logic         wrap_q, wrap_d, err_q, err_d;
  logic [DIGITS:0] ic, dc, mc;
  logic         full, digits_ok, load_ok, up_wrap, dn_wrap;
  assign ic[0] = 1'b1;
  assign dc[0] = 1'b1;
  assign mc[0] = 1'b1;
  // ripple chains: count+1, count-1, and bcd_max-1 for the wrap target
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_digit_step u_inc (.d_i(count_q[g*4 +: 4]), .dn_i(1'b0), .ci_i(ic[g]), .q_o(inc[g*4 +: 4]), .co_o(ic[g+1]));
    bcd_digit_step u_dec (.d_i(count_q[g*4 +: 4]), .dn_i(1'b1), .ci_i(dc[g]), .q_o(dec[g*4 +: 4]), .co_o(dc[g+1]));
    bcd_digit_step u_max (.d_i(bcd_max[g*4 +: 4]), .dn_i(1'b1), .ci_i(mc[g]), .q_o(max_dec[g*4 +: 4]), .co_o(mc[g+1]));
  end
  // bcd_max == 0 selects the full 10^DIGITS range, which does not fit in W bits
  always_comb begin
    full     = bcd_max == '0;
    m_minus1 = full ? ALL_NINES[W-1:0] : max_dec;
    digits_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++)
      digits_ok = digits_ok & bcd_digit_valid(load_val[i*4 +: 4]);
    load_ok = digits_ok && (full || load_val < bcd_max);
    up_wrap = count_q >= m_minus1;
    dn_wrap = count_q == '0 || (!full && count_q >= bcd_max);
  end
  // priority mux: load over step over hold; rst handled in the register
  always_comb begin
    count_d = load ? (load_ok ? load_val : count_q) :
              en   ? (dir ? (dn_wrap ? m_minus1 : dec) : (up_wrap ? '0 : inc)) :
                     count_q;
    wrap_d  = !load && en && (dir ? dn_wrap : up_wrap);
    err_d   = load && !load_ok;
  end
  // count and one-cycle event pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= RESET_VAL;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end
  assign count    = count_q;
  assign wrap     = wrap_q;
  assign load_err = err_q;
  assign at_zero  = count_q == '0;
endmodule
